spi_regbus: RTL

//  SPI mode-0 slave that turns host frames into the register-bus writes and read-back used by the motor control block.

---
 rtl/spi_regbus_pkg.sv | 22 ++
 rtl/spi_regbus_if.sv | 31 +++
 rtl/spi_regbus_syncbit.sv | 21 ++
 rtl/spi_regbus.sv | 128 ++++++++++++
 4 files changed

// File: rtl/spi_regbus_pkg.sv
// regbus_pkg: shared register-bus address map, FSM state encoding and write-decode helper for spi_regbus.
// No ports (package).
package regbus_pkg;

    localparam logic [6:0] ADDR_CTRL     = 7'h00;
    localparam logic [6:0] ADDR_WDOGDIV  = 7'h01;
    localparam logic [6:0] ADDR_WDRESET  = 7'h02;
    localparam logic [6:0] ADDR_HWCFG    = 7'h03;
    localparam logic [6:0] ADDR_CFG0     = 7'h04;
    localparam logic [6:0] ADDR_CFG1     = 7'h05;
    localparam logic [6:0] ADDR_CFG2     = 7'h06;
    localparam logic [6:0] ADDR_ABORTCNT = 7'h0E;
    localparam logic [6:0] ADDR_VERSION  = 7'h0F;

    typedef enum logic [2:0] {ARM, IDLE, CMD, DATA, DONE} state_t;

    // Addresses whose writes produce a load strobe and update wrtdata.
    function automatic logic is_strobe_addr(input logic [6:0] a);
        return a inside {ADDR_CTRL, ADDR_WDOGDIV, ADDR_WDRESET, ADDR_CFG0, ADDR_CFG1, ADDR_CFG2};
    endfunction

endpackage

// File: rtl/spi_regbus_if.sv
// spi_regbus_if: SPI pins plus register-bus read inputs and write outputs of spi_regbus.
// Signals: sck, ss_n, mosi (SPI in), miso (SPI out), controlrdata, hwconfig (read values),
//          wrtdata, ctrlld, wdogdivld, wdreset, cfgld0/1/2 (write data and strobes).
// Modports: slave (the spi_regbus block), master (host/motor-control side).
interface spi_regbus_if;

    logic       sck;
    logic       ss_n;
    logic       mosi;
    logic       miso;
    logic [7:0] controlrdata;
    logic [7:0] hwconfig;
    logic [7:0] wrtdata;
    logic       ctrlld;
    logic       wdogdivld;
    logic       wdreset;
    logic       cfgld0;
    logic       cfgld1;
    logic       cfgld2;

    modport slave (
        input  sck, ss_n, mosi, controlrdata, hwconfig,
        output miso, wrtdata, ctrlld, wdogdivld, wdreset, cfgld0, cfgld1, cfgld2
    );

    modport master (
        output sck, ss_n, mosi, controlrdata, hwconfig,
        input  miso, wrtdata, ctrlld, wdogdivld, wdreset, cfgld0, cfgld1, cfgld2
    );

endinterface

// File: rtl/spi_regbus_syncbit.sv
// syncbit: STAGES-deep flop synchroniser for one asynchronous pin, cleared by async reset.
// Ports: clk, reset (async, active-high), d (async input), q (synchronised output).
module syncbit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) ff <= '0;
        else       ff <= {ff[STAGES-2:0], d};
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/spi_regbus.sv
// spi_regbus: SPI mode-0 slave turning 16-bit host frames into register-bus writes and read-back.
// Ports: clk, reset (async, active-high), bus (spi_regbus_if.slave: sck/ss_n/mosi/miso,
//        controlrdata, hwconfig, wrtdata, ctrlld, wdogdivld, wdreset, cfgld0/1/2).
// Parameters: SYNCSTAGES (pin synchroniser depth, >=2), VERSION (value read at 0x0F).
// Optional feature: define REGBUS_ABORTCNT_EN for a saturating aborted-frame counter at 0x0E.
module spi_regbus
    import regbus_pkg::*;
#(
    parameter int         SYNCSTAGES = 2,
    parameter logic [7:0] VERSION    = 8'h01
) (
    input logic       clk,
    input logic       reset,
    spi_regbus_if.slave bus
);

    logic       s_sck, s_ss, s_mosi;
    logic       sck_d, ss_d;
    logic       rise, fall, abort;
    state_t     state;
    logic [3:0] cnt;
    logic [7:0] rx, tx, cmd, wrtdata, rd_mux, abort_rd;
    logic [6:0] addr;
    logic       pend;
    logic [5:0] strb;

    syncbit #(.STAGES(SYNCSTAGES)) u_sck  (.clk(clk), .reset(reset), .d(bus.sck),  .q(s_sck));
    syncbit #(.STAGES(SYNCSTAGES)) u_ss   (.clk(clk), .reset(reset), .d(bus.ss_n), .q(s_ss));
    syncbit #(.STAGES(SYNCSTAGES)) u_mosi (.clk(clk), .reset(reset), .d(bus.mosi), .q(s_mosi));

`ifdef REGBUS_ABORTCNT_EN
    logic [7:0] abortcnt;
    assign abort_rd = abortcnt;
`else
    assign abort_rd = 8'h00;
`endif

    assign rise = s_sck & ~sck_d;
    assign fall = ~s_sck & sck_d;
    assign addr = cmd[6:0];

    // A 16th rising edge coinciding with ss_n high wins: the frame completes rather than aborts.
    assign abort = s_ss && (state == CMD || (state == DATA && !(rise && cnt == 4'd15)));

    assign rd_mux = !cmd[7]                ? 8'h00 :
                    addr == ADDR_CTRL      ? bus.controlrdata :
                    addr == ADDR_HWCFG     ? bus.hwconfig :
                    addr == ADDR_VERSION   ? VERSION :
                    addr == ADDR_ABORTCNT  ? abort_rd : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ARM;
            cnt     <= '0;
            rx      <= '0;
            tx      <= '0;
            cmd     <= '0;
            sck_d   <= 1'b0;
            ss_d    <= 1'b0;
            pend    <= 1'b0;
            wrtdata <= '0;
            strb    <= '0;
`ifdef REGBUS_ABORTCNT_EN
            abortcnt <= '0;
`endif
        end else begin
            sck_d <= s_sck;
            ss_d  <= s_ss;
            pend  <= 1'b0;
            strb  <= '0;
            // Write commit one clk after the 16th edge: data and strobe appear together.
            if (pend) begin
                strb <= {addr == ADDR_CFG2, addr == ADDR_CFG1, addr == ADDR_CFG0,
                         addr == ADDR_WDRESET, addr == ADDR_WDOGDIV, addr == ADDR_CTRL};
                if (is_strobe_addr(addr)) wrtdata <= rx;
`ifdef REGBUS_ABORTCNT_EN
                if (addr == ADDR_ABORTCNT) abortcnt <= '0;
`endif
            end
            if (abort) begin
                state <= IDLE;
                tx    <= '0;
`ifdef REGBUS_ABORTCNT_EN
                abortcnt <= abortcnt + {7'd0, abortcnt != 8'hFF};
`endif
            end else begin
                case (state)
                    ARM:  if (s_ss) state <= IDLE;
                    IDLE: begin
                        cnt <= '0;
                        if (ss_d && !s_ss) state <= CMD;
                    end
                    CMD, DATA: begin
                        if (rise) begin
                            rx  <= {rx[6:0], s_mosi};
                            cnt <= cnt == 4'd15 ? cnt : cnt + 4'd1;
                            if (cnt == 4'd7) begin
                                cmd   <= {rx[6:0], s_mosi};
                                state <= DATA;
                            end
                            if (cnt == 4'd15) begin
                                pend  <= ~cmd[7];
                                state <= DONE;
                            end
                        end
                        // First falling edge of the data byte loads the read value; later ones shift.
                        if (fall && state == DATA) tx <= cnt == 4'd8 ? rd_mux : {tx[6:0], 1'b0};
                    end
                    DONE: if (s_ss) begin
                        state <= IDLE;
                        tx    <= '0;
                    end
                    default: state <= ARM;
                endcase
            end
        end
    end

    assign bus.miso      = tx[7];
    assign bus.wrtdata   = wrtdata;
    assign bus.ctrlld    = strb[0];
    assign bus.wdogdivld = strb[1];
    assign bus.wdreset   = strb[2];
    assign bus.cfgld0    = strb[3];
    assign bus.cfgld1    = strb[4];
    assign bus.cfgld2    = strb[5];

endmodule
